// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader state encoding, the default widths and the helpers that
// derive the byte-packing geometry (bytes per word, byte-counter width).
package imem_loader_pkg;

    localparam int unsigned INSTR_WIDTH_DEF   = 32;
    localparam int unsigned BYTE_WIDTH_DEF    = 8;
    localparam int unsigned INSTR_MEM_LEN_DEF = 15;

    // Counter width able to index n items; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned BYTES_PER_WORD = INSTR_WIDTH_DEF / BYTE_WIDTH_DEF;
    localparam int unsigned BYTE_CNT_W     = cnt_width(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer.
// Collects BPW bytes into one word; byte k lands in bits [k*BW +: BW].
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   clear          synchronous discard of any partial word (wins over accept)
//   accept         a byte is transferred this cycle
//   in_byte        byte being transferred
//   word_c         buffer with the current byte merged in (combinational)
//   word_full_c    the accepted byte completes the word (combinational)
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned BYTE_WIDTH = BYTE_WIDTH_DEF,
    parameter int unsigned WORD_WIDTH = INSTR_WIDTH_DEF,
    parameter int unsigned BPW        = BYTES_PER_WORD,
    parameter int unsigned CNT_W      = BYTE_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [BYTE_WIDTH-1:0] in_byte,
    output logic [WORD_WIDTH-1:0] word_c,
    output logic                  word_full_c
);

    localparam int unsigned LAST = BPW - 1;

    logic [WORD_WIDTH-1:0] buf_q;
    logic [CNT_W-1:0]      cnt_q;

    // Merge the incoming byte into its lane so a completed word is available
    // in the same cycle its last byte is accepted.
    always_comb begin
        word_c = buf_q;
        for (int i = 0; i < int'(BPW); i++) begin
            if (cnt_q == CNT_W'(i)) begin
                word_c[i*BYTE_WIDTH +: BYTE_WIDTH] = in_byte;
            end
        end
    end

    assign word_full_c = accept && (cnt_q == CNT_W'(LAST));

    // Buffer and byte counter; counter returns to 0 after the last lane.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            buf_q <= word_c;
            cnt_q <= (cnt_q == CNT_W'(LAST)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: packs a host byte stream into instruction words, writes
// them to instruction memory from word address 0 and holds the core in reset
// until the whole image is written.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           begin a load (honoured in IDLE/DONE only)
//   num_words       words to load, saturated to the memory depth
//   abort           cancel a load in progress
//   in_valid/in_data/in_ready   byte stream handshake
//   imem_we/imem_addr/imem_wdata  instruction memory write port
//   core_rst        active-high core reset, released when the load completes
//   busy, done      load in progress / load completed
//   checksum        XOR of every word written since the last start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH   = INSTR_WIDTH_DEF,
    parameter int unsigned INSTR_MEM_LEN = INSTR_MEM_LEN_DEF,
    parameter int unsigned BYTE_WIDTH    = BYTE_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [INSTR_MEM_LEN:0]   num_words,
    input  logic                     abort,
    input  logic                     in_valid,
    input  logic [BYTE_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     imem_we,
    output logic [INSTR_MEM_LEN-1:0] imem_addr,
    output logic [INSTR_WIDTH-1:0]   imem_wdata,
    output logic                     core_rst,
    output logic                     busy,
    output logic                     done,
    output logic [INSTR_WIDTH-1:0]   checksum
);

    localparam int unsigned BPW = INSTR_WIDTH / BYTE_WIDTH;
    localparam int unsigned CW  = INSTR_MEM_LEN + 1;
    localparam int unsigned AW  = INSTR_MEM_LEN;

    state_e               state;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        start_count_c;
    logic                 idle_start_c;
    logic                 pack_accept_c;
    logic                 pack_clear_c;
    logic [INSTR_WIDTH-1:0] word_c;
    logic                 word_full_c;

    // Any request beyond the memory depth is clamped to exactly the depth.
    assign start_count_c = num_words[INSTR_MEM_LEN] ? {1'b1, {INSTR_MEM_LEN{1'b0}}} : num_words;

    assign idle_start_c  = ((state == IDLE) || (state == DONE)) && start;
    assign pack_accept_c = (state == LOAD) && in_valid && in_ready && !abort;
    assign pack_clear_c  = idle_start_c || ((state == LOAD) && abort);

    byte_packer #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .WORD_WIDTH (INSTR_WIDTH),
        .BPW        (BPW),
        .CNT_W      (cnt_width(BPW))
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (pack_clear_c),
        .accept      (pack_accept_c),
        .in_byte     (in_data),
        .word_c      (word_c),
        .word_full_c (word_full_c)
    );

    // Loader FSM; every output is a flop updated alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            checksum   <= '0;
            count_q    <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        imem_addr <= '0;
                        checksum  <= '0;
                        count_q   <= start_count_c;
                        if (start_count_c == '0) begin
                            state    <= DONE;
                            core_rst <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state    <= LOAD;
                            core_rst <= 1'b1;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (word_full_c) begin
                        state      <= WRITE;
                        in_ready   <= 1'b0;
                        imem_we    <= 1'b1;
                        imem_wdata <= word_c;
                    end
                end
                WRITE: begin
                    // The write in flight always completes, even when aborted.
                    checksum <= checksum ^ imem_wdata;
                    count_q  <= count_q - CW'(1);
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (count_q == CW'(1)) begin
                        // Address is left on the last word written, so it never wraps.
                        state    <= DONE;
                        busy     <= 1'b0;
                        core_rst <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state     <= LOAD;
                        in_ready  <= 1'b1;
                        imem_addr <= imem_addr + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader (memory depth reduced to 16 words).
module tb_imem_loader;

    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 1 << N;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [N:0]      num_words = '0;
    logic            abort = 1'b0;
    logic            in_valid = 1'b0;
    logic [7:0]      in_data = '0;
    logic            in_ready;
    logic            imem_we;
    logic [N-1:0]    imem_addr;
    logic [31:0]     imem_wdata;
    logic            core_rst;
    logic            busy;
    logic            done;
    logic [31:0]     checksum;

    imem_loader #(.INSTR_WIDTH(32), .INSTR_MEM_LEN(N), .BYTE_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_words  (num_words),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] addr;
        logic [31:0]  data;
    } wr_t;

    wr_t          exp_q[$];
    logic [7:0]   src_bytes[$];
    int           checks = 0;
    int           errors = 0;
    int           wr_count = 0;
    bit           gaps = 1'b0;
    bit           noise = 1'b0;
    logic [31:0]  model_csum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every memory write must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rst && imem_we) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(e.addr));
                chk("write_data", imem_wdata, e.data);
                chk("ready_in_write", 32'(in_ready), 32'd0);
            end
        end
    end

    // Present one byte (optionally after idle cycles); returns at the negedge
    // after the edge that accepted it. Called and returns on a negedge.
    task automatic send_byte(input logic [7:0] b, input bit last, input wr_t e);
        int t;
        t = 0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                in_valid  = 1'b0;
                in_data   = 8'($urandom);
                start     = noise && ($urandom_range(0, 1) == 1);
                num_words = (N+1)'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready 0 for 50 cycles, expected 1");
        end else if (last) begin
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    // One load of nw words. abort_word<0: no abort. Otherwise abort after
    // abort_bytes bytes of that word (0 = abort during that word's write).
    task automatic run_load(input logic [N:0] nw, input int abort_word, input int abort_bytes);
        int          cnt;
        int          nb;
        int          wr_start;
        logic [7:0]  bytes[4];
        logic [31:0] word;
        wr_t         e;
        cnt = (int'(nw) >= int'(DEPTH)) ? int'(DEPTH) : int'(nw);
        start     = 1'b1;
        num_words = nw;
        @(negedge clk);
        start     = 1'b0;
        num_words = (N+1)'($urandom);
        model_csum = '0;
        wr_start = wr_count;
        if (cnt == 0) begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_core_rst", 32'(core_rst), 32'd0);
            chk("zero_busy", 32'(busy), 32'd0);
            chk("zero_checksum", checksum, 32'd0);
            return;
        end
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_core_rst", 32'(core_rst), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        for (int w = 0; w < cnt; w++) begin
            word = '0;
            for (int k = 0; k < 4; k++) begin
                bytes[k] = (src_bytes.size() != 0) ? src_bytes.pop_front() : 8'($urandom);
                word = word + (32'(bytes[k]) << (8 * k));
            end
            e.addr = N'(w);
            e.data = word;
            nb = (w == abort_word && abort_bytes > 0) ? abort_bytes : 4;
            for (int k = 0; k < nb; k++) send_byte(bytes[k], k == 3, e);
            if (w == abort_word) begin
                if (nb == 4) model_csum = model_csum ^ word;
                in_valid = 1'b0;
                abort    = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_core_rst", 32'(core_rst), 32'd1);
                chk("abort_in_ready", 32'(in_ready), 32'd0);
                chk("abort_checksum", checksum, model_csum);
                chk("abort_writes", 32'(wr_count - wr_start), 32'(nb == 4 ? w + 1 : w));
                return;
            end
            model_csum = model_csum ^ word;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("end_done", 32'(done), 32'd1);
        chk("end_core_rst", 32'(core_rst), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_in_ready", 32'(in_ready), 32'd0);
        chk("end_checksum", checksum, model_csum);
        chk("end_last_addr", 32'(imem_addr), 32'(cnt - 1));
        chk("end_writes", 32'(wr_count - wr_start), 32'(cnt));
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N:0] nw;
        int         aw;
        wr_t        e;
        logic [7:0] t1[8];

        // Reset values while rst is held low.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Two-word image streamed back-to-back.
        t1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        foreach (t1[i]) src_bytes.push_back(t1[i]);
        run_load((N+1)'(2), -1, 0);
        chk("t1_checksum", checksum, 32'h0010_0080);

        // abort outside a load is ignored.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_done", 32'(done), 32'd1);
        chk("idle_abort_core_rst", 32'(core_rst), 32'd0);

        // One word with a gappy stream.
        gaps = 1'b1;
        src_bytes.push_back(8'h11);
        src_bytes.push_back(8'h22);
        src_bytes.push_back(8'h33);
        src_bytes.push_back(8'h44);
        run_load((N+1)'(1), -1, 0);
        chk("t2_checksum", checksum, 32'h4433_2211);

        // Abort after two bytes, then a clean one-word load.
        run_load((N+1)'(1), 0, 2);
        run_load((N+1)'(1), -1, 0);

        // Zero-length load.
        run_load((N+1)'(0), -1, 0);

        // Asynchronous reset in the middle of a three-word load.
        gaps = 1'b0;
        start     = 1'b1;
        num_words = (N+1)'(3);
        @(negedge clk);
        start = 1'b0;
        e.addr = '0;
        e.data = 32'hA3A2_A1A0;
        send_byte(8'hA0, 1'b0, e);
        send_byte(8'hA1, 1'b0, e);
        send_byte(8'hA2, 1'b0, e);
        send_byte(8'hA3, 1'b1, e);
        send_byte(8'hB0, 1'b0, e);
        send_byte(8'hB1, 1'b0, e);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_imem_we", 32'(imem_we), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'd0);
        chk("mid_rst_wdata", imem_wdata, 32'd0);
        chk("mid_rst_core_rst", 32'(core_rst), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_checksum", checksum, 32'd0);
        chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        run_load((N+1)'(3), -1, 0);

        // Oversized request saturates at the memory depth.
        run_load((N+1)'(DEPTH + 5), -1, 0);

        // Randomized loads with gaps, ignored starts and aborts.
        for (int it = 0; it < 25; it++) begin
            gaps  = ($urandom_range(0, 1) == 1);
            noise = gaps;
            nw = ($urandom_range(0, 5) == 0) ? (N+1)'($urandom_range(DEPTH, 2 * DEPTH - 1))
                                             : (N+1)'($urandom_range(0, 6));
            aw = -1;
            if (nw != 0 && $urandom_range(0, 3) == 0)
                aw = $urandom_range(0, (int'(nw) > int'(DEPTH) ? int'(DEPTH) : int'(nw)) - 1);
            run_load(nw, aw, $urandom_range(0, 3));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader upstream of the processor core. It accepts a byte stream from the host link (UART receiver or testbench) over a valid/ready handshake and packs bytes little-endian into instruction words. It writes those words sequentially into instruction memory from word address 0. It holds the core in reset until the load completes, then releases it.

Parameters:
INSTR_WIDTH, 32, instruction word width in bits; must be a multiple of 8
INSTR_MEM_LEN, 15, instruction memory word-address width (depth = 2^INSTR_MEM_LEN words)
BYTE_WIDTH, 8, width of one input stream element

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse that begins a load; sampled only in IDLE and DONE
num_words  input  INSTR_MEM_LEN+1  word count, latched on accepted start
abort  input  1  synchronous cancel of a load in progress
in_valid  input  1  input byte valid
in_data  input  BYTE_WIDTH  input byte
in_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction memory write enable
imem_addr  output  INSTR_MEM_LEN  instruction memory word address
imem_wdata  output  INSTR_WIDTH  instruction memory write data
core_rst  output  1  active-high reset to the core
busy  output  1  load in progress
done  output  1  load completed and core released
checksum  output  INSTR_WIDTH  XOR of all words written in the current or last load

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - core_rst=1, busy=0, done=0, checksum=0
  - byte counter=0; any partial word is discarded
- All outputs are registered.
- States: IDLE, LOAD, WRITE, DONE. Encodings live in the package.
- IDLE and DONE, on start:
  - latch count = min(num_words, 2^INSTR_MEM_LEN)
  - clear byte counter, address and checksum
  - core_rst=1, done=0
  - if count=0, go to DONE with core_rst=0 and done=1 on the next cycle
  - otherwise set busy=1 and go to LOAD
- LOAD:
  - in_ready=1
  - an accepted byte (in_valid & in_ready) at counter k is placed in bits [8k+7:8k] of the word buffer
  - when the byte with k = INSTR_WIDTH/8-1 is accepted, go to WRITE
  - in_data is ignored when in_valid=0
- WRITE (exactly one cycle):
  - imem_we=1, imem_wdata=assembled word, imem_addr=current address, in_ready=0
  - checksum ^= word
  - next cycle: address+1, count-1
  - if the remaining count is 0, go to DONE; otherwise return to LOAD
- Throughput: one word per INSTR_WIDTH/8+1 cycles with a continuous stream.
- DONE: core_rst=0, busy=0, done=1, in_ready=0. Held until start.
- Restart: start in DONE reasserts core_rst on the next cycle, before any write.
- start while in LOAD or WRITE is ignored.
- abort in LOAD:
  - go to IDLE next cycle
  - partial word discarded, no write
  - core_rst stays 1, busy=0, done=0
- abort in WRITE: that cycle's write still completes, then go to IDLE.
- abort in IDLE or DONE: ignored.
- Address never wraps. A saturated count of 2^INSTR_MEM_LEN ends at the last address.
- imem_we is never asserted outside WRITE.

Decomposition:
- Package imem_loader_pkg:
  - state encodings IDLE, LOAD, WRITE, DONE
  - BYTES_PER_WORD = INSTR_WIDTH/BYTE_WIDTH
  - byte-counter width = clog2(BYTES_PER_WORD)
- Sub-module byte_packer:
  - contents: little-endian word buffer, byte counter, word_full strobe, synchronous clear
  - the top level holds the FSM, address/count registers and checksum

Test Plan:
1. Load 2 words with num_words=2; bytes 13 00 00 00 93 00 10 00 streamed back-to-back -> writes 0x00000013@0 and 0x00100093@1; checksum 0x00100080; done=1, core_rst=0 the cycle after the second write.
2. Load 1 word (bytes 0x11 22 33 44) with in_valid toggling every other cycle -> in_ready high only in LOAD; single write 0x44332211@0; no extra writes.
3. After 2 bytes of the first word, pulse abort -> no imem_we, state IDLE, core_rst=1, done=0; a following start with 1 word loads cleanly at address 0.
4. start with num_words=0 -> no write; done=1 and core_rst=0 one cycle after start; checksum=0.
5. Drive rst low mid-word during a 3-word load -> all outputs take reset values immediately; after release plus start, the load restarts at address 0.
6. With num_words=2^INSTR_MEM_LEN+5, stream a full image -> exactly 2^INSTR_MEM_LEN writes, last at address 2^INSTR_MEM_LEN-1, no wrap to 0.
